// File: rtl/conv_kxk_stream_pkg.sv
// conv_pkg: shared types and helpers for the K x K streaming convolver.
//   state_t    : frame-level state encoding (IDLE / RUN / DRAIN)
//   acc_width  : accumulator width for K*K full-width products
//   sat_q      : arithmetic shift right by Q followed by saturation to a
//                signed dw-bit range
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Widest accumulator the helpers handle (DATA_WIDTH 64 with K = 7 needs 134).
    localparam int ACC_MAX_W = 160;
    localparam logic signed [ACC_MAX_W-1:0] ONE_ACC = {{(ACC_MAX_W-1){1'b0}}, 1'b1};

    function automatic int acc_width(input int dw, input int k);
        return 2 * dw + $clog2(k * k);
    endfunction

    // Result lives in the low dw bits; the upper bits are a sign extension.
    function automatic logic signed [ACC_MAX_W-1:0] sat_q(
        input logic signed [ACC_MAX_W-1:0] acc,
        input int                          q,
        input int                          dw
    );
        logic signed [ACC_MAX_W-1:0] shifted;
        logic signed [ACC_MAX_W-1:0] hi;
        logic signed [ACC_MAX_W-1:0] lo;
        shifted = acc >>> q;
        hi      = (ONE_ACC <<< (dw - 1)) - ONE_ACC;
        lo      = -(ONE_ACC <<< (dw - 1));
        if (shifted > hi) begin
            return hi;
        end
        if (shifted < lo) begin
            return lo;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/conv_kxk_stream_if.sv
// conv_kxk_stream_if: pixel stream, weight load port and status outputs of
// the convolver.
//   ena, data_i, valid_i      : stall control and input pixel stream
//   w_we, w_addr, w_data      : weight write port (row-major tap index)
//   data_o, valid_o           : result stream
//   running_o, done_o         : frame status
// master = stream source / controller, slave = convolver.
interface conv_kxk_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 3
);
    localparam int WA_W = (K * K > 1) ? $clog2(K * K) : 1;

    logic                         ena;
    logic signed [DATA_WIDTH-1:0] data_i;
    logic                         valid_i;
    logic                         w_we;
    logic        [WA_W-1:0]       w_addr;
    logic signed [DATA_WIDTH-1:0] w_data;
    logic signed [DATA_WIDTH-1:0] data_o;
    logic                         valid_o;
    logic                         running_o;
    logic                         done_o;

    modport master (
        output ena, data_i, valid_i, w_we, w_addr, w_data,
        input  data_o, valid_o, running_o, done_o
    );

    modport slave (
        input  ena, data_i, valid_i, w_we, w_addr, w_data,
        output data_o, valid_o, running_o, done_o
    );
endinterface

// File: rtl/conv_kxk_stream_line_buffer.sv
// conv_line_buffer: one image row of delay. Each enabled cycle it stores
// i_data and presents the value written DEPTH enables earlier on o_data.
//   clk, rst : clock, synchronous active-high reset (clears contents)
//   i_en     : shift strobe
//   i_data   : value entering the row
//   o_data   : value leaving the row (combinational read of oldest entry)
module conv_line_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    output logic signed [DATA_WIDTH-1:0] o_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic        [PTR_W-1:0]      r_ptr;

    // Circular buffer: the slot about to be overwritten holds the oldest value.
    assign o_data = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_en) begin
            r_mem[r_ptr] <= i_data;
            r_ptr        <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/conv_kxk_stream.sv
// conv_kxk_stream: streaming "valid"-mode K x K convolution over one N x N
// frame of signed Q-format pixels in raster order.
//   clk, rst : clock, synchronous active-high reset
//   bus      : conv_kxk_stream_if.slave
//              ena       freezes all pipeline state when low
//              data_i / valid_i   input pixel stream
//              w_we / w_addr / w_data  weight writes, honoured only when idle
//              data_o / valid_o   saturated result stream, latency 3 enabled
//                                 cycles from the window-completing accept
//              running_o frame in progress, done_o end-of-frame pulse
module conv_kxk_stream
    import conv_pkg::*;
#(
    parameter int N          = 100,
    parameter int K          = 3,
    parameter int DATA_WIDTH = 32,
    parameter int Q          = 10
) (
    input logic              clk,
    input logic              rst,
    conv_kxk_stream_if.slave bus
);
    localparam int KK     = K * K;
    localparam int CENTRE = KK / 2;
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = acc_width(DATA_WIDTH, K);
    localparam int WA_W   = (KK > 1) ? $clog2(KK) : 1;
    localparam int RC_W   = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W  = $clog2(N * N + 1);

    localparam logic [CNT_W-1:0] PIX_LAST    = CNT_W'(N * N - 1);
    localparam logic [CNT_W-1:0] PIX_FULL    = CNT_W'(N * N);
    localparam logic [RC_W-1:0]  RC_LAST     = RC_W'(N - 1);
    localparam logic [RC_W-1:0]  RC_KM1      = RC_W'(K - 1);
    localparam logic [WA_W-1:0]  W_ADDR_LAST = WA_W'(KK - 1);
    localparam logic signed [DATA_WIDTH-1:0] ONE_Q = DATA_WIDTH'(1 << Q);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_done_nxt;
    logic   r_done;

    logic [CNT_W-1:0] r_pixel_cnt;
    logic [RC_W-1:0]  r_row;
    logic [RC_W-1:0]  r_col;
    logic             w_closing;
    logic             w_accept;
    logic             w_win_valid;

    logic signed [DATA_WIDTH-1:0] r_w   [KK];
    logic signed [DATA_WIDTH-1:0] r_win [KK];
    // w_tap[d] is the pixel d rows above the incoming one, same column.
    logic signed [DATA_WIDTH-1:0] w_tap [K];

    logic signed [PROD_W-1:0]     r_prod_p1 [KK];
    logic signed [ACC_W-1:0]      w_sum;
    logic signed [ACC_W-1:0]      r_acc_p2;
    logic signed [ACC_MAX_W-1:0]  w_sat;
    logic signed [DATA_WIDTH-1:0] r_data_p3;
    logic                         w_unused_sat;
    logic                         r_vld_p0;
    logic                         r_vld_p1;
    logic                         r_vld_p2;
    logic                         r_vld_p3;

    // Once all N*N pixels are in, further valid_i is ignored until done.
    assign w_closing   = (r_state != IDLE) && (r_pixel_cnt == PIX_FULL);
    assign w_accept    = bus.ena && bus.valid_i && !w_closing;
    assign w_win_valid = (r_row >= RC_KM1) && (r_col >= RC_KM1);

    // ---------------- frame control ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                // A 1x1 frame is complete on its very first accept.
                if (w_accept) begin
                    w_state_nxt = (r_pixel_cnt == PIX_LAST) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (w_accept && (r_pixel_cnt == PIX_LAST)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The output being presented now is the last one in flight.
                if (bus.ena && r_vld_p3 && !r_vld_p0 && !r_vld_p1 && !r_vld_p2) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_done_nxt) begin
            r_pixel_cnt <= '0;
            r_row       <= '0;
            r_col       <= '0;
        end else if (w_accept) begin
            r_pixel_cnt <= r_pixel_cnt + 1'b1;
            if (r_col == RC_LAST) begin
                r_col <= '0;
                r_row <= (r_row == RC_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KK; i++) begin
                r_w[i] <= (i == CENTRE) ? ONE_Q : '0;
            end
        end else if (bus.w_we && (r_state == IDLE) && (bus.w_addr <= W_ADDR_LAST)) begin
            r_w[bus.w_addr] <= bus.w_data;
        end
    end

    // ---------------- window construction (on accept) ----------------
    assign w_tap[0] = bus.data_i;

    for (genvar g = 1; g < K; g++) begin : g_lb
        conv_line_buffer #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (N)
        ) u_line_buffer (
            .clk   (clk),
            .rst   (rst),
            .i_en  (w_accept),
            .i_data(w_tap[g-1]),
            .o_data(w_tap[g])
        );
    end

    // r_win[ky*K+kx] = pixel(row-K+1+ky, col-K+1+kx) of the last accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int ky = 0; ky < K; ky++) begin
                for (int kx = 0; kx < K; kx++) begin
                    if (kx < K - 1) begin
                        r_win[ky*K+kx] <= r_win[ky*K+kx+1];
                    end else begin
                        r_win[ky*K+kx] <= w_tap[K-1-ky];
                    end
                end
            end
        end
    end

    // ---------------- pipeline valids ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_vld_p3 <= 1'b0;
        end else if (bus.ena) begin
            r_vld_p0 <= w_accept && w_win_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
            r_vld_p3 <= r_vld_p2;
        end
    end

    // ---------------- stage 1: full-width products ----------------
    always_ff @(posedge clk) begin
        if (bus.ena) begin
            for (int i = 0; i < KK; i++) begin
                r_prod_p1[i] <= PROD_W'(r_win[i]) * PROD_W'(r_w[i]);
            end
        end
    end

    // ---------------- stage 2: accumulate ----------------
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < KK; i++) begin
            w_sum = w_sum + ACC_W'(r_prod_p1[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (bus.ena) begin
            r_acc_p2 <= w_sum;
        end
    end

    // ---------------- stage 3: rescale and saturate ----------------
    assign w_sat        = sat_q({{(ACC_MAX_W-ACC_W){r_acc_p2[ACC_W-1]}}, r_acc_p2}, Q, DATA_WIDTH);
    assign w_unused_sat = ^w_sat[ACC_MAX_W-1:DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_p3 <= '0;
        end else if (bus.ena) begin
            r_data_p3 <= w_sat[DATA_WIDTH-1:0];
        end
    end

    // A stalled cycle hides the pending result; it reappears once ena returns.
    assign bus.data_o    = r_data_p3;
    assign bus.valid_o   = r_vld_p3 && bus.ena;
    assign bus.running_o = (r_state != IDLE);
    assign bus.done_o    = r_done;
endmodule

// File: tb/tb_conv_kxk_stream.sv
module tb_conv_kxk_stream;
    localparam int N  = 8;
    localparam int K  = 3;
    localparam int DW = 32;
    localparam int Q  = 10;
    localparam int NO = (N - K + 1) * (N - K + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_kxk_stream_if #(.DATA_WIDTH(DW), .K(K)) bus ();

    conv_kxk_stream #(.N(N), .K(K), .DATA_WIDTH(DW), .Q(Q)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          img [N*N];
    int          mw  [K*K];
    logic [31:0] exp_q [$];
    int          lit_mode = 0;
    logic [31:0] lit_val = '0;
    int          frame_out = 0;
    int          first_vcyc = 0;
    int          done_cnt = 0;
    int          frames_done = 0;
    bit          mon_en = 1'b0;
    logic [31:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference: valid-mode correlation, floor shift by Q, clamp to 32 bits.
    function automatic void build_expected();
        logic signed [95:0] acc;
        logic signed [95:0] a;
        logic signed [95:0] b;
        for (int i = 0; i <= N - K; i++) begin
            for (int j = 0; j <= N - K; j++) begin
                acc = '0;
                for (int ky = 0; ky < K; ky++) begin
                    for (int kx = 0; kx < K; kx++) begin
                        a = mw[ky*K+kx];
                        b = img[(i+ky)*N + j + kx];
                        acc = acc + a * b;
                    end
                end
                acc = acc >>> Q;
                if (acc > 96'sd2147483647) exp_q.push_back(32'h7FFF_FFFF);
                else if (acc < -96'sd2147483648) exp_q.push_back(32'h8000_0000);
                else exp_q.push_back(acc[31:0]);
            end
        end
    endfunction

    function automatic logic [31:0] ramp_val(input int k);
        int i;
        int j;
        i = k / (N - K + 1);
        j = k % (N - K + 1);
        return 32'((8 * (i + 1) + j + 1) << 10);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.done_o) begin
                done_cnt++;
                check("done_running", {63'b0, bus.running_o}, 64'd0);
            end
            if (!bus.ena) begin
                check("stall_valid", {63'b0, bus.valid_o}, 64'd0);
            end else if (bus.valid_o) begin
                if (frame_out == 0) first_vcyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_output: got %0h expected no output", bus.data_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data_o", {32'b0, bus.data_o}, {32'b0, mon_e});
                end
                if (lit_mode == 1) check("ramp_lit", {32'b0, bus.data_o}, {32'b0, ramp_val(frame_out)});
                else if (lit_mode == 2) check("const_lit", {32'b0, bus.data_o}, {32'b0, lit_val});
                frame_out++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.ena = 1'b1;
        bus.valid_i = 1'b0;
        repeat (n) step();
    endtask

    task automatic write_weight(input int a, input int d);
        bus.ena = 1'b1;
        bus.valid_i = 1'b0;
        bus.w_we = 1'b1;
        bus.w_addr = 4'(a);
        bus.w_data = d;
        step();
        bus.w_we = 1'b0;
        mw[a] = d;
    endtask

    task automatic set_all_weights(input int d);
        for (int i = 0; i < K * K; i++) write_weight(i, d);
    endtask

    task automatic set_identity();
        for (int i = 0; i < K * K; i++) write_weight(i, (i == (K * K) / 2) ? 1024 : 0);
    endtask

    task automatic set_ramp();
        for (int p = 0; p < N * N; p++) img[p] = ((p / N) * 8 + (p % N)) << 10;
    endtask

    task automatic run_frame(input int stall_at, input int stall_len, input int drain_stall,
                             input bit tamper, input bit extra, input int gap_pct, input bit chk_lat);
        int acc18;
        bit got_done;
        build_expected();
        frame_out = 0;
        acc18 = -100;
        got_done = 1'b0;
        for (int p = 0; p < N * N; p++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.ena = 1'b0;
                    bus.valid_i = 1'b1;
                end else begin
                    bus.ena = 1'b1;
                    bus.valid_i = 1'b0;
                end
                bus.data_i = $urandom();
                step();
            end
            bus.ena = 1'b1;
            bus.valid_i = 1'b1;
            bus.data_i = img[p];
            if (p == 18) acc18 = cyc + 1;
            if (tamper && p == 20) begin
                bus.w_we = 1'b1;
                bus.w_addr = 4'd4;
                bus.w_data = 0;
            end
            step();
            bus.w_we = 1'b0;
            if (p == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.ena = 1'b0;
                    bus.valid_i = 1'b1;
                    bus.data_i = $urandom();
                    step();
                end
            end
        end
        bus.ena = 1'b1;
        bus.valid_i = extra;
        bus.data_i = $urandom();
        for (int t = 0; t < 80; t++) begin
            if (bus.done_o) begin
                got_done = 1'b1;
                break;
            end
            bus.ena = !(drain_stall > 0 && t >= 1 && t < 1 + drain_stall);
            if (extra) bus.data_i = $urandom();
            step();
        end
        bus.ena = 1'b1;
        if (got_done) frames_done++;
        check("done_seen", {63'b0, got_done}, 64'd1);
        check("out_count", 64'(frame_out), 64'(NO));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        if (chk_lat) check("latency", 64'(first_vcyc - acc18), 64'd3);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.ena = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i = '0;
        bus.w_we = 1'b0;
        bus.w_addr = '0;
        bus.w_data = '0;
        repeat (3) step();
        bus.ena = 1'b1;
        #1;
        check("rst_data_o", {32'b0, bus.data_o}, 64'd0);
        check("rst_valid_o", {63'b0, bus.valid_o}, 64'd0);
        check("rst_running_o", {63'b0, bus.running_o}, 64'd0);
        check("rst_done_o", {63'b0, bus.done_o}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < K * K; i++) mw[i] = (i == (K * K) / 2) ? 1024 : 0;
        mon_en = 1'b1;
        idle(2);

        // Model pins on the identity/ramp case.
        set_ramp();
        build_expected();
        check("model_first", {32'b0, exp_q[0]}, 64'd9216);
        check("model_last", {32'b0, exp_q[NO-1]}, 64'd55296);
        exp_q.delete();

        // Default weights, ramp.
        lit_mode = 1;
        run_frame(-1, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        idle(2);

        // All ones, pixels 2.0.
        set_all_weights(1024);
        for (int p = 0; p < N * N; p++) img[p] = 2048;
        lit_mode = 2;
        lit_val = 32'd18432;
        run_frame(-1, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        idle(2);

        // Positive and negative saturation.
        set_all_weights(1024000);
        for (int p = 0; p < N * N; p++) img[p] = 1024000;
        lit_val = 32'h7FFF_FFFF;
        run_frame(-1, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        idle(2);
        set_all_weights(-1024000);
        lit_val = 32'h8000_0000;
        run_frame(-1, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        idle(2);

        // Stalls mid-frame and during drain.
        set_identity();
        set_ramp();
        lit_mode = 1;
        run_frame(30, 5, 2, 1'b0, 1'b0, 0, 1'b1);
        idle(2);

        // Mid-frame weight write dropped, extra valid_i ignored, back-to-back frame.
        run_frame(-1, 0, 0, 1'b1, 1'b1, 0, 1'b1);
        lit_mode = 0;
        for (int p = 0; p < N * N; p++) img[p] = int'($urandom_range(0, 65535)) - 32768;
        run_frame(-1, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        idle(2);

        // Randomised weights, pixels and stall/gap pattern.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < K * K; i++) write_weight(i, int'($urandom_range(0, 8191)) - 4096);
            for (int p = 0; p < N * N; p++) begin
                if ($urandom_range(0, 3) == 0) img[p] = int'($urandom());
                else img[p] = int'($urandom_range(0, 65535)) - 32768;
            end
            run_frame(int'($urandom_range(0, 63)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 3)), 1'b0, 1'b0, 20, 1'b0);
            idle(1);
        end

        // Reset at pixel 40 with non-identity weights loaded.
        set_ramp();
        build_expected();
        frame_out = 0;
        for (int p = 0; p <= 40; p++) begin
            bus.ena = 1'b1;
            bus.valid_i = 1'b1;
            bus.data_i = img[p];
            step();
        end
        rst = 1'b1;
        bus.valid_i = 1'b0;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("midrst_valid_o", {63'b0, bus.valid_o}, 64'd0);
        check("midrst_running_o", {63'b0, bus.running_o}, 64'd0);
        check("midrst_done_o", {63'b0, bus.done_o}, 64'd0);
        for (int i = 0; i < K * K; i++) mw[i] = (i == (K * K) / 2) ? 1024 : 0;
        idle(2);
        lit_mode = 1;
        run_frame(-1, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        idle(3);

        check("done_total", 64'(done_cnt), 64'(frames_done));
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
